// File: rtl/fir_coeff_sched_if.sv
// Coefficient-load and sample streams between a data source and fir_coeff_sched.
// The source side is the master; the controller is the slave.
interface fir_coeff_sched_if #(
    parameter int NB = 11
);
    logic          CFG_START;
    logic          CFG_VALID;
    logic [NB-1:0] CFG_DATA;
    logic          CFG_READY;
    logic [NB-1:0] DIN;
    logic          VIN;
    logic          DIN_READY;

    modport master (
        output CFG_START, CFG_VALID, CFG_DATA, DIN, VIN,
        input  CFG_READY, DIN_READY
    );

    modport slave (
        input  CFG_START, CFG_VALID, CFG_DATA, DIN, VIN,
        output CFG_READY, DIN_READY
    );
endinterface

// File: rtl/fir_coeff_sched.sv
// Coefficient loader and sequencer for an ORDER-th order FIR: shadow load, atomic commit, flush, run.
// Define FIR_CTRL_TIMEOUT_EN to abort a stalled load after TIMEOUT idle cycles and raise a sticky ERR.
module fir_coeff_sched #(
    parameter int NB      = 11,
    parameter int ORDER   = 8,
    parameter int TIMEOUT = 64
) (
    input  logic                    CLK,
    input  logic                    RST_n,
    fir_coeff_sched_if.slave        bus,
    output logic [NB-1:0]           DOUT_FIR,
    output logic                    VOUT_FIR,
    output logic [(ORDER+1)*NB-1:0] H_FLAT,
    output logic                    LOADED,
    output logic [1:0]              STATE_O,
    output logic                    ERR
);
    localparam int IW = $clog2(ORDER + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_FLUSH = 2'd2,
        S_RUN   = 2'd3
    } state_t;

    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("fir_coeff_sched: TIMEOUT must be at least 1");
    end

    state_t        state, state_nxt;
    logic [NB-1:0] shadow [ORDER+1];
    logic [IW-1:0] idx;
    logic [IW:0]   flush_cnt;
    logic          cfg_ready_q;
    logic          loaded_q;
    logic          err_q;
    logic          accept, last_word, abort, pass;

    assign accept    = bus.CFG_VALID & cfg_ready_q;
    assign last_word = accept && (idx == IW'(ORDER));

`ifdef FIR_CTRL_TIMEOUT_EN
    localparam int GW = $clog2(TIMEOUT + 1);
    logic [GW-1:0] gap_cnt;

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            gap_cnt <= '0;
            err_q   <= 1'b0;
        end else begin
            if (state != S_LOAD || accept) gap_cnt <= '0;
            else                           gap_cnt <= gap_cnt + 1'b1;
            if (abort) err_q <= 1'b1;
        end
    end

    assign abort = (state == S_LOAD) && !accept && (gap_cnt == GW'(TIMEOUT - 1));
`else
    assign abort = 1'b0;
    assign err_q = 1'b0;
`endif

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (bus.CFG_START) state_nxt = S_LOAD;
            S_LOAD: begin
                if (last_word)  state_nxt = S_FLUSH;
                else if (abort) state_nxt = loaded_q ? S_RUN : S_IDLE;
            end
            S_FLUSH: if (flush_cnt == (IW+1)'(1)) state_nxt = S_RUN;
            S_RUN:   if (bus.CFG_START) state_nxt = S_LOAD;
            default: state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state       <= S_IDLE;
            cfg_ready_q <= 1'b0;
            idx         <= '0;
            flush_cnt   <= '0;
            loaded_q    <= 1'b0;
            H_FLAT      <= '0;
            // NOTE: the shadow bank is reset because a reset must discard any partial load.
            for (int i = 0; i <= ORDER; i++) shadow[i] <= '0;
        end else begin
            state       <= state_nxt;
            cfg_ready_q <= (state_nxt == S_LOAD);

            if (state != S_LOAD && state_nxt == S_LOAD) idx <= '0;
            else if (accept) idx <= last_word ? '0 : idx + 1'b1;

            if (abort) begin
                for (int i = 0; i <= ORDER; i++) shadow[i] <= '0;
            end else if (accept) begin
                shadow[idx] <= bus.CFG_DATA;
            end

            // The last word goes straight into H_FLAT so the whole set lands on one edge.
            if (last_word) begin
                for (int i = 0; i < ORDER; i++) H_FLAT[i*NB +: NB] <= shadow[i];
                H_FLAT[ORDER*NB +: NB] <= bus.CFG_DATA;
                loaded_q  <= 1'b1;
                flush_cnt <= (IW+1)'(ORDER + 1);
            end else if (state == S_FLUSH) begin
                flush_cnt <= flush_cnt - 1'b1;
            end
        end
    end

    // A reload started from RUN keeps the old coefficients serving samples until commit.
    assign pass          = (state == S_RUN) || (state == S_LOAD && loaded_q);
    assign bus.DIN_READY = pass;
    assign bus.CFG_READY = cfg_ready_q;
    assign VOUT_FIR      = pass ? bus.VIN : (state == S_FLUSH);
    assign DOUT_FIR      = (pass && bus.VIN) ? bus.DIN : '0;
    assign LOADED        = loaded_q;
    assign STATE_O       = state;
    assign ERR           = err_q;
endmodule

// File: doc/fir_coeff_sched.md
Name: fir_coeff_sched

Overview:
- Configuration and sequencing controller in front of the 8th-order FIR (`myfir`).
- Accepts ORDER+1 coefficients over a valid/ready stream into shadow registers, then commits them atomically to the filter's H0..H8 inputs.
- After each commit it flushes the FIR delay line with zero samples, then gates the sample stream (DIN/VIN) into the FIR.
- Sits between the data source and `myfir`.

Parameters:
NB, 11, sample and coefficient width in bits
ORDER, 8, filter order; ORDER+1 coefficients are loaded
TIMEOUT, 64, max idle cycles between coefficient words in LOAD (used only with the optional feature)

Ports:
CLK  in  1  clock; all state updates on rising edge
RST_n  in  1  asynchronous, active-low reset
CFG_START  in  1  one-cycle pulse requesting a coefficient (re)load
CFG_VALID  in  1  CFG_DATA valid
CFG_DATA  in  NB  coefficient word; H0 first, H[ORDER] last
CFG_READY  out  1  controller accepts CFG_DATA
DIN  in  NB  input sample from source
VIN  in  1  input sample valid
DIN_READY  out  1  controller can forward a sample this cycle
DOUT_FIR  out  NB  sample driven to FIR DIN
VOUT_FIR  out  1  valid driven to FIR VIN
H_FLAT  out  (ORDER+1)*NB  committed coefficients; H0 in bits [NB-1:0]
LOADED  out  1  at least one complete coefficient set committed since reset
STATE_O  out  2  state code: IDLE=0, LOAD=1, FLUSH=2, RUN=3
ERR  out  1  sticky load-abort flag (optional feature only; otherwise constant 0)

Behaviour:
- Reset (async, RST_n=0):
  - state IDLE; H_FLAT, shadow registers, word index and flush counter = 0.
  - LOADED=0, ERR=0, CFG_READY=0, DIN_READY=0, VOUT_FIR=0, DOUT_FIR=0.
  - Reset mid-LOAD or mid-FLUSH discards everything, including H_FLAT.
- IDLE:
  - DIN_READY=0, VOUT_FIR=0; samples are not forwarded.
  - CFG_START=1 -> LOAD on the next edge, word index cleared to 0.
- LOAD:
  - CFG_READY=1.
  - Each cycle with CFG_VALID&CFG_READY writes CFG_DATA to shadow[index] and increments index.
  - CFG_VALID low: index holds, no write.
  - Accepting the word at index=ORDER -> on the next edge: H_FLAT <= shadow (all ORDER+1 words in the same edge, including the last word), LOADED<=1, state FLUSH, flush counter = ORDER+1.
  - CFG_START during LOAD is ignored; no restart.
  - If entered from RUN with LOADED=1: samples keep passing with the old H_FLAT (DIN_READY=1, VOUT_FIR=VIN, DOUT_FIR=DIN). Otherwise DIN_READY=0, VOUT_FIR=0.
  - H_FLAT never shows a partial set.
- FLUSH:
  - CFG_READY=0, DIN_READY=0.
  - VOUT_FIR=1, DOUT_FIR=0 for exactly ORDER+1 consecutive cycles (counter decrements each cycle).
  - Counter reaching 0 -> RUN.
  - CFG_START during FLUSH is ignored.
- RUN:
  - Combinational pass-through: DIN_READY=1, VOUT_FIR=VIN, DOUT_FIR=DIN (DOUT_FIR=0 when VIN=0); zero added latency.
  - CFG_START=1 -> LOAD on the next edge. A VIN sample in the same cycle is still forwarded.
- CFG_READY is registered, derived from state only; never combinationally dependent on CFG_VALID.
- Upstream holds DIN/VIN while DIN_READY=0. The controller never drops or duplicates a sample while DIN_READY=1.
- Word index width = clog2(ORDER+1). Index never exceeds ORDER; CFG_VALID after the last word is not accepted (CFG_READY already 0 in FLUSH).

Optional Feature:
FIR_CTRL_TIMEOUT_EN
- Defined:
  - In LOAD, a gap counter increments on each cycle without an accepted word and clears on each accepted word.
  - Gap reaching TIMEOUT -> abort: shadow discarded, H_FLAT unchanged, ERR<=1 (sticky until reset).
  - Next state after abort: RUN if LOADED=1, else IDLE.
- Undefined: no gap counter; LOAD waits indefinitely; ERR tied to 0.

Test Plan:
- Reset, then CFG_START with words 1..9 streamed back-to-back -> CFG_READY high for 9 accepts; H_FLAT = {9,8,...,1} (H0=1) one edge after the 9th accept; VOUT_FIR=1 with DOUT_FIR=0 for exactly 9 cycles; then STATE_O=3.
- RUN with VIN=1, DIN=11'h155 -> DOUT_FIR=11'h155 and VOUT_FIR=1 in the same cycle; VIN=0 -> VOUT_FIR=0 and DOUT_FIR=0.
- Load from RUN with CFG_VALID toggling every other cycle -> samples still forwarded during LOAD; H_FLAT keeps the old set until the last word, then changes in one edge; flush follows.
- Pulse RST_n low after 4 coefficient words -> all outputs 0 immediately (async); STATE_O=0; LOADED=0.
- CFG_START pulses during LOAD and during FLUSH -> no effect: index continues, flush length stays ORDER+1.
- With FIR_CTRL_TIMEOUT_EN, TIMEOUT=64: send 3 words then stall 64 cycles -> ERR=1; H_FLAT unchanged; state returns to RUN if LOADED=1, else IDLE.
